// File: rtl/spoofer_avst_source_if.sv
// Avalon-ST stream bundle (ready latency 0) carried between the spoofer source
// and the sink under test.
interface spoofer_avst_source_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;
   logic                  sop;
   logic                  eop;

   modport master (output data, output valid, output sop, output eop, input ready);
   modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/spoofer_avst_source.sv
// Samples the spoofer counter, strobes it forward, buffers words in a 2-deep FIFO
// and emits them as fixed-length Avalon-ST packets.
module spoofer_avst_source #(
   parameter int DATA_WIDTH    = 32,
   parameter int PACKET_LEN    = 256,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] count_in,
   output logic                  read_signal,
   output logic [15:0]           pkt_count,
   spoofer_avst_source_if.master avst
);

   localparam int BEAT_W   = $clog2(PACKET_LEN);
   localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [BEAT_W-1:0]   LAST_BEAT   = BEAT_W'(PACKET_LEN - 1);
   localparam logic [SETTLE_W-1:0] LAST_SETTLE = SETTLE_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_PULSE,
      ST_SETTLE
   } state_t;

   state_t                state_q, state_d;
   logic [SETTLE_W-1:0]   settle_q, settle_d;
   logic [BEAT_W-1:0]     issue_q, issue_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [15:0]           pkt_q, pkt_d;
   logic [DATA_WIDTH-1:0] mem_q [2];
   logic [DATA_WIDTH-1:0] mem_d [2];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            fill_q, fill_d;

   logic fifo_full;
   logic fifo_empty;
   logic fifo_wr;
   logic handshake;
   logic stop_pending;

   assign fifo_full    = (fill_q == 2'd2);
   assign fifo_empty   = (fill_q == 2'd0);
   assign handshake    = !fifo_empty && avst.ready;
   // Stopping is only allowed once the issued words form whole packets.
   assign stop_pending = !enable && (issue_q == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
         issue_q  <= '0;
         beat_q   <= '0;
         pkt_q    <= '0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         fill_q   <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         issue_q  <= issue_d;
         beat_q   <= beat_d;
         pkt_q    <= pkt_d;
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (enable) state_d = ST_CAPTURE;
         ST_CAPTURE: if (!fifo_full) state_d = ST_PULSE;
         ST_PULSE:   state_d = ST_SETTLE;
         ST_SETTLE:  if (settle_q == LAST_SETTLE) state_d = stop_pending ? ST_IDLE : ST_CAPTURE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      read_signal = 1'b0;
      fifo_wr     = 1'b0;
      case (state_q)
         ST_CAPTURE: fifo_wr     = !fifo_full;
         ST_PULSE:   read_signal = 1'b1;
         default:    ;
      endcase
   end

   always_comb begin
      settle_d = (state_q == ST_SETTLE) ? settle_q + SETTLE_W'(1) : '0;

      issue_d = issue_q;
      if (fifo_wr) begin
         issue_d = (issue_q == LAST_BEAT) ? '0 : issue_q + BEAT_W'(1);
      end

      mem_d[0] = mem_q[0];
      mem_d[1] = mem_q[1];
      if (fifo_wr) begin
         mem_d[wr_ptr_q] = count_in;
      end
      wr_ptr_d = wr_ptr_q ^ fifo_wr;
      rd_ptr_d = rd_ptr_q ^ handshake;

      fill_d = fill_q;
      case ({fifo_wr, handshake})
         2'b10:   fill_d = fill_q + 2'd1;
         2'b01:   fill_d = fill_q - 2'd1;
         default: fill_d = fill_q;
      endcase

      beat_d = beat_q;
      pkt_d  = pkt_q;
      if (handshake) begin
         beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
         if (beat_q == LAST_BEAT) begin
            pkt_d = pkt_q + 16'd1;
         end
      end
   end

   assign avst.valid = !fifo_empty;
   assign avst.data  = mem_q[rd_ptr_q];
   assign avst.sop   = !fifo_empty && (beat_q == '0);
   assign avst.eop   = !fifo_empty && (beat_q == LAST_BEAT);
   assign pkt_count  = pkt_q;

endmodule

// File: tb/tb_spoofer_avst_source.sv
// Directed bench for spoofer_avst_source with a behavioural spoofer_counter model
// whose value advances a few cycles after each read_signal pulse.
module tb_spoofer_avst_source;

   localparam int DW     = 32;
   localparam int PLEN   = 4;
   localparam int SETTLE = 3;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [31:0] ctr;
   logic        read_signal;
   logic [15:0] pkt_count;

   spoofer_avst_source_if #(.DATA_WIDTH(DW)) avst_bus ();

   spoofer_avst_source #(
      .DATA_WIDTH   (DW),
      .PACKET_LEN   (PLEN),
      .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .count_in   (ctr),
      .read_signal(read_signal),
      .pkt_count  (pkt_count),
      .avst       (avst_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter model: two-flop edge path, then a 24-bit wrapping increment.
   logic        rs_d1, rs_d2;
   logic        ctr_load;
   logic [31:0] ctr_load_val;
   always @(posedge clk) begin
      if (ctr_load) begin
         ctr   <= ctr_load_val;
         rs_d1 <= 1'b0;
         rs_d2 <= 1'b0;
      end else begin
         rs_d1 <= read_signal;
         rs_d2 <= rs_d1;
         if (rs_d2) ctr <= (ctr == 32'h00FF_FFFF) ? 32'h0 : ctr + 32'd1;
      end
   end

   typedef struct {
      int          stall;
      bit          drop_enable;
      logic [31:0] exp_data;
      logic        exp_sop;
      logic        exp_eop;
      logic [15:0] exp_pkt;
   } vec_t;

   vec_t vecs [12];
   int   assertions;
   int   failures;
   int   pulse_count;
   int   low_run;
   logic en_cur;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertions++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic rdy);
      enable         = en;
      avst_bus.ready = rdy;
   endtask

   // Every cycle advance also audits read_signal width and spacing.
   task automatic tick();
      @(negedge clk);
      if (read_signal === 1'b1) begin
         pulse_count++;
         checkOutput("strobe_spacing", (low_run >= SETTLE) ? 32'd1 : 32'd0, 32'd1);
         low_run = 0;
      end else begin
         low_run++;
      end
   endtask

   task automatic waitValid();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (avst_bus.valid === 1'b1) got = 1'b1;
         else tick();
      end
      checkOutput("valid_timeout", {31'd0, got}, 32'd1);
   endtask

   task automatic collectBeat(output logic [31:0] d, output logic s, output logic e, output logic [15:0] p);
      bit got;
      got = 1'b0;
      d = '0; s = 1'b0; e = 1'b0; p = '0;
      for (int i = 0; i < 100 && !got; i++) begin
         tick();
         if (avst_bus.valid === 1'b1 && avst_bus.ready === 1'b1) begin
            got = 1'b1;
            d = avst_bus.data; s = avst_bus.sop; e = avst_bus.eop; p = pkt_count;
         end
      end
      checkOutput("beat_timeout", {31'd0, got}, 32'd1);
   endtask

   initial begin
      logic [31:0] hold;
      logic [31:0] d;
      logic        s, e;
      logic [15:0] p;
      logic [31:0] wrap_data [4];
      int          p0;
      int          valid_seen;

      assertions = 0; failures = 0; pulse_count = 0; low_run = 100;
      vecs[0]  = '{0,  1'b0, 32'd0,  1'b1, 1'b0, 16'd0};
      vecs[1]  = '{0,  1'b0, 32'd1,  1'b0, 1'b0, 16'd0};
      vecs[2]  = '{20, 1'b0, 32'd2,  1'b0, 1'b0, 16'd0};
      vecs[3]  = '{0,  1'b0, 32'd3,  1'b0, 1'b1, 16'd0};
      vecs[4]  = '{0,  1'b0, 32'd4,  1'b1, 1'b0, 16'd1};
      vecs[5]  = '{3,  1'b0, 32'd5,  1'b0, 1'b0, 16'd1};
      vecs[6]  = '{0,  1'b0, 32'd6,  1'b0, 1'b0, 16'd1};
      vecs[7]  = '{0,  1'b0, 32'd7,  1'b0, 1'b1, 16'd1};
      vecs[8]  = '{0,  1'b0, 32'd8,  1'b1, 1'b0, 16'd2};
      vecs[9]  = '{0,  1'b1, 32'd9,  1'b0, 1'b0, 16'd2};
      vecs[10] = '{0,  1'b0, 32'd10, 1'b0, 1'b0, 16'd2};
      vecs[11] = '{0,  1'b0, 32'd11, 1'b0, 1'b1, 16'd2};
      wrap_data[0] = 32'h00FF_FFFE; wrap_data[1] = 32'h00FF_FFFF;
      wrap_data[2] = 32'h0000_0000; wrap_data[3] = 32'h0000_0001;

      rst_n = 1'b0; ctr_load = 1'b1; ctr_load_val = 32'd0;
      applyStimulus(1'b0, 1'b0);
      tick();
      ctr_load = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checkOutput("reset_valid", {31'd0, avst_bus.valid}, 32'd0);
      checkOutput("reset_sop", {31'd0, avst_bus.sop}, 32'd0);
      checkOutput("reset_eop", {31'd0, avst_bus.eop}, 32'd0);
      checkOutput("reset_read_signal", {31'd0, read_signal}, 32'd0);
      checkOutput("reset_pkt_count", {16'd0, pkt_count}, 32'd0);

      en_cur = 1'b1;
      applyStimulus(en_cur, 1'b0);
      tick();
      checkOutput("startup_not_yet_valid", {31'd0, avst_bus.valid}, 32'd0);
      tick();
      checkOutput("startup_valid", {31'd0, avst_bus.valid}, 32'd1);
      checkOutput("startup_sop", {31'd0, avst_bus.sop}, 32'd1);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(en_cur, 1'b0);
         waitValid();
         hold = avst_bus.data;
         p0 = pulse_count;
         for (int st = 0; st < vecs[i].stall; st++) begin
            if (st == 10) p0 = pulse_count;
            tick();
            checkOutput("bp_valid_stable", {31'd0, avst_bus.valid}, 32'd1);
            checkOutput("bp_data_stable", avst_bus.data, hold);
         end
         if (vecs[i].stall >= 20) checkOutput("bp_no_strobe", pulse_count - p0, 32'd0);
         checkOutput($sformatf("vec%0d_data", i), avst_bus.data, vecs[i].exp_data);
         checkOutput($sformatf("vec%0d_sop", i), {31'd0, avst_bus.sop}, {31'd0, vecs[i].exp_sop});
         checkOutput($sformatf("vec%0d_eop", i), {31'd0, avst_bus.eop}, {31'd0, vecs[i].exp_eop});
         checkOutput($sformatf("vec%0d_pkt", i), {16'd0, pkt_count}, {16'd0, vecs[i].exp_pkt});
         applyStimulus(en_cur, 1'b1);
         tick();
         if (vecs[i].drop_enable) en_cur = 1'b0;
      end
      applyStimulus(en_cur, 1'b0);

      valid_seen = 0;
      p0 = pulse_count;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (avst_bus.valid !== 1'b0) valid_seen++;
      end
      checkOutput("stop_valid_quiet", valid_seen, 32'd0);
      checkOutput("stop_no_strobe", pulse_count - p0, 32'd0);
      checkOutput("strobes_vs_words", pulse_count, 32'd12);
      checkOutput("stop_pkt_count", {16'd0, pkt_count}, 32'd3);

      // Counter wrap with the sink always ready.
      rst_n = 1'b0; ctr_load = 1'b1; ctr_load_val = 32'h00FF_FFFE; low_run = 100;
      tick();
      ctr_load = 1'b0;
      tick();
      rst_n = 1'b1; pulse_count = 0;
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         collectBeat(d, s, e, p);
         checkOutput($sformatf("wrap%0d_data", i), d, wrap_data[i]);
         checkOutput($sformatf("wrap%0d_sop", i), {31'd0, s}, (i == 0) ? 32'd1 : 32'd0);
         checkOutput($sformatf("wrap%0d_eop", i), {31'd0, e}, (i == 3) ? 32'd1 : 32'd0);
      end
      collectBeat(d, s, e, p);
      checkOutput("wrap_next_data", d, 32'd2);
      checkOutput("wrap_next_sop", {31'd0, s}, 32'd1);
      checkOutput("wrap_pkt_count", {16'd0, p}, 32'd1);
      collectBeat(d, s, e, p);
      checkOutput("wrap_next2_data", d, 32'd3);
      tick();

      // Reset lands mid-packet at beat 2.
      rst_n = 1'b0; ctr_load = 1'b1; ctr_load_val = 32'h0000_0100; low_run = 100;
      tick();
      ctr_load = 1'b0;
      checkOutput("midrst_valid", {31'd0, avst_bus.valid}, 32'd0);
      checkOutput("midrst_read_signal", {31'd0, read_signal}, 32'd0);
      checkOutput("midrst_pkt_count", {16'd0, pkt_count}, 32'd0);
      tick();
      rst_n = 1'b1; pulse_count = 0;
      collectBeat(d, s, e, p);
      checkOutput("postrst_data", d, 32'h0000_0100);
      checkOutput("postrst_sop", {31'd0, s}, 32'd1);
      checkOutput("postrst_pkt_count", {16'd0, p}, 32'd0);
      collectBeat(d, s, e, p);
      checkOutput("postrst_next_data", d, 32'h0000_0101);
      checkOutput("postrst_next_sop", {31'd0, s}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
